// File: rtl/exec_stage_pipe.sv
// Execute stage: ALU, barrel shift and multi-cycle signed multiply with NZVC flags and a valid/ready/stall/flush handshake.
// Optional macro EXEC_MULHI_EN enables the signed high-half multiply result for ResSel 11.
module exec_stage_pipe #(
  parameter int DATA_W  = 64,
  parameter int SHAMT_W = $clog2(DATA_W),
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic               flush,
  input  logic               stall_in,
  input  logic [DATA_W-1:0]  DataA_Reg,
  input  logic [DATA_W-1:0]  DataB_Reg,
  input  logic [DATA_W-1:0]  ALU_in_Reg,
  input  logic [SHAMT_W-1:0] SHAMT_Reg,
  input  logic               SFTDir_Reg,
  input  logic [2:0]         ALUOp_Reg,
  input  logic [1:0]         ResSel_Reg,
  input  logic               SetFlag_Reg,
  input  logic               MemWrite_Reg,
  input  logic               MemRead_Reg,
  input  logic               RegWrite_Reg,
  input  logic [REG_AW-1:0]  Rd_Reg,
  output logic [DATA_W-1:0]  ALU_out,
  output logic               NewNegative,
  output logic               NewZero,
  output logic               NewOverflow,
  output logic               NewCarryout,
  output logic               negative,
  output logic               zero,
  output logic               overflow,
  output logic               carryout,
  output logic               valid_ex,
  output logic [DATA_W-1:0]  Result_Ex,
  output logic [DATA_W-1:0]  DataB_Ex,
  output logic               MemWrite_Ex,
  output logic               MemRead_Ex,
  output logic               RegWrite_Ex,
  output logic [REG_AW-1:0]  Rd_Ex,
  output logic               busy
);

  localparam int MSB = DATA_W - 1;
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam bit MUL_MULTI = (MUL_LAT > 1);

  localparam logic [2:0] OP_PASSB = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;

  logic                    accept;
  logic                    is_mul;
  logic                    issue_now;
  logic                    mul_done;
  logic [CNT_W-1:0]        mul_cnt;

  logic [DATA_W-1:0]       alu_res;
  logic [DATA_W:0]         sum_w;
  logic                    alu_c;
  logic                    alu_v;
  logic [DATA_W-1:0]       shift_res;
  logic [DATA_W-1:0]       sel_res;

  logic signed [DATA_W-1:0] mul_a;
  logic signed [DATA_W-1:0] mul_b;
  logic signed [DATA_W-1:0] mul_res;

  logic signed [DATA_W-1:0] mul_a_p0;
  logic signed [DATA_W-1:0] mul_b_p0;
  logic [REG_AW-1:0]        rd_p0;
  logic                     mw_p0;
  logic                     mr_p0;
  logic                     rw_p0;

  assign ready_out = !busy && !stall_in;
  assign accept    = valid_in && ready_out && !flush;
  assign is_mul    = ResSel_Reg[1];
  assign issue_now = accept && (!is_mul || !MUL_MULTI);
  // Completion fires once the countdown has expired (or is expiring) and Mem can take it.
  assign mul_done  = busy && (mul_cnt <= CNT_W'(1)) && !stall_in && !flush;

  // ---- Stage p0: combinational ALU, shifter and multiplier ----
  always_comb begin
    alu_res = '0;
    sum_w   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUOp_Reg)
      OP_PASSB: alu_res = ALU_in_Reg;
      OP_ADD: begin
        sum_w   = {1'b0, DataA_Reg} + {1'b0, ALU_in_Reg};
        alu_res = sum_w[MSB:0];
        alu_c   = sum_w[DATA_W];
        alu_v   = (DataA_Reg[MSB] == ALU_in_Reg[MSB]) && (alu_res[MSB] != DataA_Reg[MSB]);
      end
      OP_SUB: begin
        sum_w   = {1'b0, DataA_Reg} + {1'b0, ~ALU_in_Reg} + (DATA_W+1)'(1);
        alu_res = sum_w[MSB:0];
        alu_c   = sum_w[DATA_W];
        alu_v   = (DataA_Reg[MSB] != ALU_in_Reg[MSB]) && (alu_res[MSB] != DataA_Reg[MSB]);
      end
      OP_AND:  alu_res = DataA_Reg & ALU_in_Reg;
      OP_OR:   alu_res = DataA_Reg | ALU_in_Reg;
      OP_XOR:  alu_res = DataA_Reg ^ ALU_in_Reg;
      default: alu_res = '0;
    endcase
  end

  assign ALU_out     = alu_res;
  assign NewNegative = alu_res[MSB];
  assign NewZero     = (alu_res == '0);
  assign NewOverflow = alu_v;
  assign NewCarryout = alu_c;

  assign shift_res = SFTDir_Reg ? (DataA_Reg >> SHAMT_Reg) : (DataA_Reg << SHAMT_Reg);

  // While a multiply is in flight the operands come from the holding registers.
  assign mul_a = busy ? mul_a_p0 : DataA_Reg;
  assign mul_b = busy ? mul_b_p0 : DataB_Reg;

`ifdef EXEC_MULHI_EN
  logic                       mul_hi_p0;
  logic                       mul_hi;
  logic signed [2*DATA_W-1:0] mul_a_x;
  logic signed [2*DATA_W-1:0] mul_b_x;
  logic signed [2*DATA_W-1:0] product;

  assign mul_a_x = {{DATA_W{mul_a[MSB]}}, mul_a};
  assign mul_b_x = {{DATA_W{mul_b[MSB]}}, mul_b};
  assign product = mul_a_x * mul_b_x;
  assign mul_hi  = busy ? mul_hi_p0 : ResSel_Reg[0];
  assign mul_res = mul_hi ? product[2*DATA_W-1:DATA_W] : product[MSB:0];

  always_ff @(posedge clk) begin
    if (accept && is_mul)
      mul_hi_p0 <= ResSel_Reg[0];
  end
`else
  assign mul_res = mul_a * mul_b;
`endif

  always_comb begin
    case (ResSel_Reg)
      2'b00:   sel_res = alu_res;
      2'b01:   sel_res = shift_res;
      default: sel_res = mul_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mul_a_p0 <= DataA_Reg;
      mul_b_p0 <= DataB_Reg;
      rd_p0    <= Rd_Reg;
      mw_p0    <= MemWrite_Reg;
      mr_p0    <= MemRead_Reg;
      rw_p0    <= RegWrite_Reg;
    end
  end

  // ---- Stage p1: flags, multiply sequencing and output registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      negative <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      carryout <= 1'b0;
    end else if (accept && SetFlag_Reg) begin
      negative <= NewNegative;
      zero     <= NewZero;
      overflow <= NewOverflow;
      carryout <= NewCarryout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      mul_cnt     <= '0;
      valid_ex    <= 1'b0;
      RegWrite_Ex <= 1'b0;
      MemWrite_Ex <= 1'b0;
      MemRead_Ex  <= 1'b0;
    end else if (flush) begin
      busy        <= 1'b0;
      mul_cnt     <= '0;
      valid_ex    <= 1'b0;
      RegWrite_Ex <= 1'b0;
      MemWrite_Ex <= 1'b0;
      MemRead_Ex  <= 1'b0;
    end else begin
      if (accept && is_mul && MUL_MULTI) begin
        busy    <= 1'b1;
        mul_cnt <= CNT_INIT;
      end else if (mul_done) begin
        busy    <= 1'b0;
        mul_cnt <= '0;
      end else if (busy && mul_cnt != '0) begin
        mul_cnt <= mul_cnt - CNT_W'(1);
      end

      if (!stall_in) begin
        if (mul_done) begin
          valid_ex    <= 1'b1;
          RegWrite_Ex <= rw_p0;
          MemWrite_Ex <= mw_p0;
          MemRead_Ex  <= mr_p0;
        end else if (issue_now) begin
          valid_ex    <= 1'b1;
          RegWrite_Ex <= RegWrite_Reg;
          MemWrite_Ex <= MemWrite_Reg;
          MemRead_Ex  <= MemRead_Reg;
        end else begin
          valid_ex    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Result_Ex <= '0;
      DataB_Ex  <= '0;
      Rd_Ex     <= '0;
    end else if (!flush && !stall_in) begin
      if (mul_done) begin
        Result_Ex <= mul_res;
        DataB_Ex  <= mul_b_p0;
        Rd_Ex     <= rd_p0;
      end else if (issue_now) begin
        Result_Ex <= sel_res;
        DataB_Ex  <= DataB_Reg;
        Rd_Ex     <= Rd_Reg;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Directed bench for exec_stage_pipe: a cycle-level reference model checked every cycle plus literal expectations.
module tb_exec_stage_pipe;

  localparam int DW = 64;
  localparam int SW = 6;
  localparam int RW = 5;
  localparam int ML = 3;

  typedef struct packed {
    logic        n;
    logic        z;
    logic        v;
    logic        c;
    logic [63:0] r;
  } alu_t;

  logic          clk = 1'b0;
  logic          reset, valid_in, ready_out, flush, stall_in;
  logic [DW-1:0] DataA_Reg, DataB_Reg, ALU_in_Reg;
  logic [SW-1:0] SHAMT_Reg;
  logic          SFTDir_Reg;
  logic [2:0]    ALUOp_Reg;
  logic [1:0]    ResSel_Reg;
  logic          SetFlag_Reg, MemWrite_Reg, MemRead_Reg, RegWrite_Reg;
  logic [RW-1:0] Rd_Reg;
  logic [DW-1:0] ALU_out;
  logic          NewNegative, NewZero, NewOverflow, NewCarryout;
  logic          negative, zero, overflow, carryout;
  logic          valid_ex;
  logic [DW-1:0] Result_Ex, DataB_Ex;
  logic          MemWrite_Ex, MemRead_Ex, RegWrite_Ex;
  logic [RW-1:0] Rd_Ex;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_stage_pipe #(.DATA_W(DW), .SHAMT_W(SW), .REG_AW(RW), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .flush(flush), .stall_in(stall_in),
    .DataA_Reg(DataA_Reg), .DataB_Reg(DataB_Reg), .ALU_in_Reg(ALU_in_Reg),
    .SHAMT_Reg(SHAMT_Reg), .SFTDir_Reg(SFTDir_Reg), .ALUOp_Reg(ALUOp_Reg),
    .ResSel_Reg(ResSel_Reg), .SetFlag_Reg(SetFlag_Reg),
    .MemWrite_Reg(MemWrite_Reg), .MemRead_Reg(MemRead_Reg), .RegWrite_Reg(RegWrite_Reg),
    .Rd_Reg(Rd_Reg), .ALU_out(ALU_out),
    .NewNegative(NewNegative), .NewZero(NewZero), .NewOverflow(NewOverflow), .NewCarryout(NewCarryout),
    .negative(negative), .zero(zero), .overflow(overflow), .carryout(carryout),
    .valid_ex(valid_ex), .Result_Ex(Result_Ex), .DataB_Ex(DataB_Ex),
    .MemWrite_Ex(MemWrite_Ex), .MemRead_Ex(MemRead_Ex), .RegWrite_Ex(RegWrite_Ex),
    .Rd_Ex(Rd_Ex), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU from arithmetic definitions: carry as unsigned no-wrap/no-borrow, overflow as out-of-range signed result.
  function automatic alu_t alu_ref(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    alu_t o;
    logic [64:0] uw;
    logic signed [65:0] sw;
    o = '0;
    uw = '0;
    sw = '0;
    case (op)
      3'b000: o.r = b;
      3'b010: begin
        uw  = {1'b0, a} + {1'b0, b};
        o.r = uw[63:0];
        o.c = uw[64];
        sw  = {{2{a[63]}}, a} + {{2{b[63]}}, b};
        o.v = (sw[64] != sw[63]);
      end
      3'b011: begin
        o.r = a - b;
        o.c = (a >= b);
        sw  = {{2{a[63]}}, a} - {{2{b[63]}}, b};
        o.v = (sw[64] != sw[63]);
      end
      3'b100: o.r = a & b;
      3'b101: o.r = a | b;
      3'b110: o.r = a ^ b;
      default: o.r = '0;
    endcase
    o.n = o.r[63];
    o.z = (o.r == 64'd0);
    return o;
  endfunction

  function automatic logic [63:0] exp_res(input logic [1:0] rs, input logic [63:0] alu_r,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [5:0] sh, input logic dir);
    logic [127:0] p;
    p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
    case (rs)
      2'b00:   return alu_r;
      2'b01:   return dir ? (a >> sh) : (a << sh);
`ifdef EXEC_MULHI_EN
      2'b11:   return p[127:64];
`endif
      default: return p[63:0];
    endcase
  endfunction

  // Reference model state: registered outputs plus one pending multiply with its due edge.
  bit          m_init = 1'b0;
  int          m_cyc = 0;
  bit          m_valid;
  logic [63:0] m_res, m_datab;
  logic [4:0]  m_rd;
  logic [2:0]  m_ctl;
  logic [3:0]  m_flags;
  bit          m_pend;
  int          m_due;
  logic [63:0] p_res, p_datab;
  logic [4:0]  p_rd;
  logic [2:0]  p_ctl;
  bit          acc;
  alu_t        m_alu;
  alu_t        c_alu;
  logic [63:0] now_res;

  always @(posedge clk) begin
    m_cyc++;
    if (reset) begin
      m_init  = 1'b1;
      m_valid = 1'b0;
      m_res   = '0;
      m_datab = '0;
      m_rd    = '0;
      m_ctl   = '0;
      m_flags = '0;
      m_pend  = 1'b0;
    end else if (m_init) begin
      acc     = valid_in && !m_pend && !stall_in && !flush;
      m_alu   = alu_ref(ALUOp_Reg, DataA_Reg, ALU_in_Reg);
      now_res = exp_res(ResSel_Reg, m_alu.r, DataA_Reg, DataB_Reg, SHAMT_Reg, SFTDir_Reg);
      if (acc && SetFlag_Reg)
        m_flags = {m_alu.n, m_alu.z, m_alu.v, m_alu.c};
      if (flush) begin
        m_valid = 1'b0;
        m_ctl   = '0;
        m_pend  = 1'b0;
      end else begin
        if (!stall_in) begin
          if (m_pend && m_cyc >= m_due) begin
            m_valid = 1'b1;
            m_res   = p_res;
            m_datab = p_datab;
            m_rd    = p_rd;
            m_ctl   = p_ctl;
            m_pend  = 1'b0;
          end else if (acc && (!ResSel_Reg[1] || ML == 1)) begin
            m_valid = 1'b1;
            m_res   = now_res;
            m_datab = DataB_Reg;
            m_rd    = Rd_Reg;
            m_ctl   = {RegWrite_Reg, MemWrite_Reg, MemRead_Reg};
          end else begin
            m_valid = 1'b0;
          end
        end
        if (acc && ResSel_Reg[1] && ML > 1) begin
          m_pend  = 1'b1;
          m_due   = m_cyc + ML - 1;
          p_res   = now_res;
          p_datab = DataB_Reg;
          p_rd    = Rd_Reg;
          p_ctl   = {RegWrite_Reg, MemWrite_Reg, MemRead_Reg};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      c_alu = alu_ref(ALUOp_Reg, DataA_Reg, ALU_in_Reg);
      chk("alu_out", ALU_out, c_alu.r);
      chk("new_flags", 64'({NewNegative, NewZero, NewOverflow, NewCarryout}), 64'({c_alu.n, c_alu.z, c_alu.v, c_alu.c}));
      chk("flags", 64'({negative, zero, overflow, carryout}), 64'(m_flags));
      chk("valid_ex", 64'(valid_ex), 64'(m_valid));
      chk("busy", 64'(busy), 64'(m_pend));
      chk("ready_out", 64'(ready_out), 64'(!m_pend && !stall_in));
      chk("ctl_ex", 64'({RegWrite_Ex, MemWrite_Ex, MemRead_Ex}), 64'(m_ctl));
      if (m_valid) begin
        chk("result_ex", Result_Ex, m_res);
        chk("datab_ex", DataB_Ex, m_datab);
        chk("rd_ex", 64'(Rd_Ex), 64'(m_rd));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in     = 1'b0;
    DataA_Reg    = '0;
    DataB_Reg    = '0;
    ALU_in_Reg   = '0;
    SHAMT_Reg    = '0;
    SFTDir_Reg   = 1'b0;
    ALUOp_Reg    = 3'b000;
    ResSel_Reg   = 2'b00;
    SetFlag_Reg  = 1'b0;
    MemWrite_Reg = 1'b0;
    MemRead_Reg  = 1'b0;
    RegWrite_Reg = 1'b0;
    Rd_Reg       = '0;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [1:0] rs, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] alub, input logic [5:0] sh,
                        input logic dir, input logic sf, input logic [4:0] rd);
    valid_in     = 1'b1;
    ALUOp_Reg    = op;
    ResSel_Reg   = rs;
    DataA_Reg    = a;
    DataB_Reg    = b;
    ALU_in_Reg   = alub;
    SHAMT_Reg    = sh;
    SFTDir_Reg   = dir;
    SetFlag_Reg  = sf;
    Rd_Reg       = rd;
    RegWrite_Reg = 1'b1;
    MemWrite_Reg = rd[0];
    MemRead_Reg  = rd[1];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; stall_in = 1'b0;
    idle();
    step(); step();
    chk("rst_valid", 64'(valid_ex), 64'd0);
    chk("rst_result", Result_Ex, 64'd0);
    chk("rst_datab", DataB_Ex, 64'd0);
    chk("rst_rd_ctl", 64'({Rd_Ex, RegWrite_Ex, MemWrite_Ex, MemRead_Ex}), 64'd0);
    chk("rst_flags", 64'({negative, zero, overflow, carryout}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    set_op(3'b010, 2'b00, 64'd5, 64'd7, 64'd7, 6'd0, 1'b0, 1'b1, 5'd3);
    step(); idle();
    chk("add_result", Result_Ex, 64'd12);
    chk("add_valid", 64'(valid_ex), 64'd1);
    chk("add_nzvc", 64'({negative, zero, overflow, carryout}), 64'h0);

    set_op(3'b011, 2'b00, 64'd3, 64'd3, 64'd3, 6'd0, 1'b0, 1'b1, 5'd4);
    step(); idle();
    chk("sub_eq_nzvc", 64'({negative, zero, overflow, carryout}), 64'b0101);
    chk("sub_eq_result", Result_Ex, 64'd0);

    set_op(3'b011, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 1'b0, 1'b1, 5'd5);
    step(); idle();
    chk("sub_ovf_nzvc", 64'({negative, zero, overflow, carryout}), 64'b1010);
    chk("sub_ovf_result", Result_Ex, 64'h8000_0000_0000_0000);

    // Back-to-back single-cycle ops
    set_op(3'b100, 2'b00, 64'hF0F0, 64'd1, 64'hFF00, 6'd0, 1'b0, 1'b0, 5'd6);
    step();
    chk("and_result", Result_Ex, 64'hF000);
    set_op(3'b101, 2'b00, 64'hF0F0, 64'd2, 64'h0F0F, 6'd0, 1'b0, 1'b0, 5'd7);
    step();
    chk("or_result", Result_Ex, 64'hFFFF);
    set_op(3'b110, 2'b00, 64'hFF, 64'd3, 64'hFF, 6'd0, 1'b0, 1'b1, 5'd8);
    step();
    chk("xor_nzvc", 64'({negative, zero, overflow, carryout}), 64'b0100);
    set_op(3'b000, 2'b00, 64'd9, 64'd4, 64'h1234, 6'd0, 1'b0, 1'b0, 5'd9);
    step();
    chk("passb_result", Result_Ex, 64'h1234);
    set_op(3'b001, 2'b00, 64'd5, 64'd5, 64'd6, 6'd0, 1'b0, 1'b0, 5'd10);
    step();
    chk("undef_op_result", Result_Ex, 64'd0);
    set_op(3'b010, 2'b01, 64'd1, 64'd6, 64'd1, 6'd63, 1'b0, 1'b0, 5'd11);
    step();
    set_op(3'b010, 2'b01, 64'hF0, 64'd7, 64'd1, 6'd4, 1'b1, 1'b0, 5'd12);
    chk("shl63_result", Result_Ex, 64'h8000_0000_0000_0000);
    step(); idle();
    chk("shr4_result", Result_Ex, 64'h0F);
    chk("shr4_valid", 64'(valid_ex), 64'd1);
    step();
    chk("drain_valid", 64'(valid_ex), 64'd0);

    // Stall holds a live result
    set_op(3'b010, 2'b00, 64'd1, 64'd1, 64'd1, 6'd0, 1'b0, 1'b0, 5'd13);
    step(); idle(); stall_in = 1'b1;
    step();
    chk("stall_hold_valid", 64'(valid_ex), 64'd1);
    chk("stall_hold_result", Result_Ex, 64'd2);
    stall_in = 1'b0;
    step();

    // Multiply -3 * 4
    set_op(3'b000, 2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'd0, 6'd0, 1'b0, 1'b0, 5'd7);
    step(); idle();
    chk("mul_busy0", 64'({busy, ready_out}), 64'b10);
    step();
    chk("mul_busy1", 64'({busy, ready_out, valid_ex}), 64'b100);
    step();
    chk("mul_done_valid", 64'({busy, ready_out, valid_ex}), 64'b011);
    chk("mul_lo_result", Result_Ex, 64'hFFFF_FFFF_FFFF_FFF4);
    chk("mul_rd", 64'(Rd_Ex), 64'd7);

    set_op(3'b000, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'd0, 6'd0, 1'b0, 1'b0, 5'd8);
    step(); idle(); step(); step();
`ifdef EXEC_MULHI_EN
    chk("mul_hi_result", Result_Ex, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    chk("mul_hi_result", Result_Ex, 64'hFFFF_FFFF_FFFF_FFF4);
`endif

    // Stall on the completion cycle for two cycles
    set_op(3'b000, 2'b10, 64'd6, 64'd7, 64'd0, 6'd0, 1'b0, 1'b0, 5'd4);
    step(); idle();
    step(); stall_in = 1'b1;
    step();
    chk("mul_stall1", 64'({busy, valid_ex}), 64'b10);
    step();
    chk("mul_stall2", 64'({busy, valid_ex}), 64'b10);
    stall_in = 1'b0;
    step();
    chk("mul_stall_emit", 64'({busy, valid_ex}), 64'b01);
    chk("mul_stall_result", Result_Ex, 64'd42);
    step();
    chk("mul_no_dup", 64'(valid_ex), 64'd0);

    // Flush aborts an in-flight multiply; flags untouched
    set_op(3'b000, 2'b10, 64'd2, 64'd2, 64'd0, 6'd0, 1'b0, 1'b0, 5'd2);
    step();
    set_op(3'b011, 2'b00, 64'd5, 64'd5, 64'd1, 6'd0, 1'b0, 1'b1, 5'd3);
    flush = 1'b1;
    step(); flush = 1'b0; idle();
    chk("flush_busy_valid", 64'({busy, valid_ex}), 64'b00);
    chk("flush_flags", 64'({negative, zero, overflow, carryout}), 64'b0100);
    step(); step();
    chk("flush_no_result", 64'({busy, valid_ex}), 64'b00);

    // Flush kills a live output
    set_op(3'b010, 2'b00, 64'd4, 64'd4, 64'd4, 6'd0, 1'b0, 1'b0, 5'd1);
    step(); idle(); flush = 1'b1;
    step(); flush = 1'b0;
    chk("flush_out", 64'({valid_ex, RegWrite_Ex, MemWrite_Ex, MemRead_Ex}), 64'd0);

    // Reset mid-multiply
    set_op(3'b000, 2'b10, 64'd3, 64'd3, 64'd0, 6'd0, 1'b0, 1'b0, 5'd5);
    step(); idle(); reset = 1'b1;
    step(); reset = 1'b0;
    chk("rst_mul_busy", 64'({busy, valid_ex}), 64'b00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mul_quiet", 64'(valid_ex), 64'd0);
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
